pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 clk  in  1  pipeline clock; all state updates on the falling edge, matching the pipeline registers.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 id_rs_used, id_rt_used  in  1 each  the ID instruction reads rs / rt.
REQ-006 ex_mem_read  in  1  the ID/EX register holds a load (its mem_read_out).
REQ-007 ex_rt  in  5  the load's destination register (the ID/EX rt_out).
REQ-008 ex_redirect  in  1  a branch is taken or a jump resolves in EX.
REQ-009 mem_access  in  1  the MEM stage performs a load or store.
REQ-010 icache_hit, dcache_hit  in  1 each  the cache hit indications (1 = hit).
REQ-011 pc_en, if_id_en, id_ex_hit, ex_mem_en, mem_wb_en  out  1 each  load enables for the PC and each pipeline register; id_ex_hit drives the ID/EX hit input.
REQ-012 if_id_flush, id_ex_flush  out  1 each  bubble insertion: the register loads a NOP/zero control word.
REQ-013 state  out  2  FSM state (RUN=0, IMISS=1, DMISS=2).
REQ-014 stall_cnt, flush_cnt  out  CNT_W each  event counters.

Function
REQ-015 Control outputs are combinational from state and inputs; state and counters are registered.
REQ-016 load_use = ex_mem_read && ex_rt != 0 && ((id_rs_used && id_rs == ex_rt) || (id_rt_used && id_rt == ex_rt)).
REQ-017 dmiss = mem_access && !dcache_hit; imiss = !icache_hit.
REQ-018 Priority per cycle: dmiss > ex_redirect > load_use > imiss > normal.
REQ-019 Rule dmiss: all five enables are 0 and both flushes are 0, so the whole pipe freezes.
REQ-020 Rule redirect: all enables are 1 and if_id_flush = id_ex_flush = 1.
REQ-021 Rule load_use: pc_en = if_id_en = 0, id_ex_flush = 1, and the later stages advance.
REQ-022 Rule imiss: pc_en = if_id_en = 0, id_ex_flush = 1, and the later stages advance.
REQ-023 Rule normal: all enables are 1 and both flushes are 0.
REQ-024 FSM in RUN: dmiss goes to DMISS; otherwise imiss without redirect goes to IMISS; otherwise it stays in RUN.
REQ-025 FSM in IMISS: dmiss goes to DMISS; redirect or icache_hit goes to RUN; otherwise it stays in IMISS.
REQ-026 FSM in DMISS: it stays while dmiss holds; otherwise it goes to RUN, with IMISS as the next state if imiss holds.
REQ-027 An ex_redirect arriving during a D-miss is not lost: EX is frozen, so it is applied on the first cycle after dcache_hit.
REQ-028 A redirect during an I-miss aborts the miss: the PC loads the target and the cache sees the new address.
REQ-029 Simultaneous load_use and redirect resolve as the redirect, with no extra stall.
REQ-030 stall_cnt increments on every falling edge where pc_en = 0 and saturates at all-ones.
REQ-031 flush_cnt increments on every edge where the redirect rule applies and saturates at all-ones.
REQ-032 Latency: the hazard response takes zero cycles (same-cycle combinational); a load-use stall lasts exactly one cycle.

Reset
REQ-033 While rst_n = 0: state = RUN, both counters = 0, all enables = 0, all flushes = 0.
REQ-034 Reset asserted mid-miss abandons the miss immediately, with no extra cycle.
REQ-035 The first falling edge after rst_n deasserts evaluates the rules normally.

Structure
REQ-036 Package pipe_ctrl_pkg holds the state enum (RUN, IMISS, DMISS) and the CNT_W default.
REQ-037 The load_use comparison is a combinational sub-module named hazard_detect; the FSM and counters stay in pipe_ctrl.

Verification
REQ-038 Load-use: ex_mem_read = 1, ex_rt = 5, id_rs = 5, id_rs_used = 1 -> for one cycle pc_en = 0, id_ex_flush = 1, stall_cnt += 1; next cycle normal.
REQ-039 Register $0: ex_rt = 0 matching id_rs = 0 -> no stall.
REQ-040 D-miss 4 cycles with ex_redirect = 1 throughout -> enables 0 for 4 cycles, state DMISS, stall_cnt = 4; then one redirect cycle, flush_cnt = 1.
REQ-041 I-miss then redirect on its 3rd cycle -> state IMISS then RUN; pc_en = 1 and if_id_flush = 1 in the redirect cycle.
REQ-042 Saturation: CNT_W = 4 with 20 stall cycles -> stall_cnt = 15.
REQ-043 Reset asserted during DMISS -> state = RUN and counters = 0 asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared types for the pipeline hazard controller.
//   state_t : controller FSM encoding (RUN=0, IMISS=1, DMISS=2)
//   rule_t  : the hazard rule selected in the current cycle
//   CNT_W_DEFAULT : default width of the stall/flush event counters
package pipe_ctrl_pkg;

  localparam int unsigned CNT_W_DEFAULT = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DMISS = 2'd2
  } state_t;

  // Per-cycle rule, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    RULE_RESET    = 3'd0,
    RULE_DMISS    = 3'd1,
    RULE_REDIRECT = 3'd2,
    RULE_LOAD_USE = 3'd3,
    RULE_IMISS    = 3'd4,
    RULE_NORMAL   = 3'd5
  } rule_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// hazard_detect -- combinational load-use hazard check.
//   id_rs, id_rt         : source registers of the instruction in ID
//   id_rs_used/id_rt_used: ID instruction actually reads rs / rt
//   ex_mem_read          : ID/EX holds a load
//   ex_rt                : destination register of that load
//   load_use             : 1 when ID must wait one cycle for the load
module hazard_detect (
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = id_rs_used && (id_rs == ex_rt);
    rt_match = id_rt_used && (id_rt == ex_rt);
    // $0 is hard-wired to zero, so a load into it can never create a hazard.
    load_use = ex_mem_read && (ex_rt != 5'd0) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline stall/flush controller with I/D cache miss FSM.
//   clk, rst_n        : clock (state updates on falling edge), async active-low reset
//   id_rs/id_rt(+used): ID-stage source operands
//   ex_mem_read, ex_rt: load sitting in ID/EX and its destination
//   ex_redirect       : taken branch / jump resolved in EX
//   mem_access        : MEM stage does a load or store
//   icache_hit, dcache_hit : cache hit flags
//   pc_en .. mem_wb_en: load enables for PC and pipeline registers
//   if_id_flush, id_ex_flush : insert a bubble into IF/ID, ID/EX
//   state             : FSM state (RUN/IMISS/DMISS)
//   stall_cnt, flush_cnt : saturating event counters
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_redirect,
  input  logic             mem_access,
  input  logic             icache_hit,
  input  logic             dcache_hit,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_hit,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t cur_state;
  rule_t  rule;
  logic   load_use;
  logic   dmiss;
  logic   imiss;

  hazard_detect u_hazard_detect (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rs_used  (id_rs_used),
    .id_rt_used  (id_rt_used),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  assign dmiss = mem_access && !dcache_hit;
  assign imiss = !icache_hit;
  assign state = cur_state;

  // Rule selection. Reset is folded in here so the enables drop to zero the
  // moment rst_n falls, not at the next clock edge.
  always_comb begin
    if (!rst_n)           rule = RULE_RESET;
    else if (dmiss)       rule = RULE_DMISS;
    else if (ex_redirect) rule = RULE_REDIRECT;
    else if (load_use)    rule = RULE_LOAD_USE;
    else if (imiss)       rule = RULE_IMISS;
    else                  rule = RULE_NORMAL;
  end

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_hit   = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (rule)
      RULE_RESET, RULE_DMISS: begin
        // Whole pipe frozen: a D-miss holds EX too, so a pending redirect
        // stays in EX and is applied once the data cache returns.
      end
      RULE_REDIRECT: begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_hit   = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      RULE_LOAD_USE, RULE_IMISS: begin
        // Hold PC and IF/ID, send a bubble down from ID, drain the rest.
        id_ex_hit   = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        id_ex_flush = 1'b1;
      end
      default: begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_hit = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    endcase
  end

  // FSM and counters, clocked on the falling edge like the pipeline registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= RUN;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      unique case (cur_state)
        RUN: begin
          if (dmiss)                     cur_state <= DMISS;
          else if (imiss && !ex_redirect) cur_state <= IMISS;
          else                           cur_state <= RUN;
        end
        IMISS: begin
          if (dmiss)                          cur_state <= DMISS;
          else if (ex_redirect || icache_hit) cur_state <= RUN;
          else                                cur_state <= IMISS;
        end
        DMISS: begin
          if (dmiss)      cur_state <= DMISS;
          else if (imiss) cur_state <= IMISS;
          else            cur_state <= RUN;
        end
        default: cur_state <= RUN;
      endcase

      if (!pc_en && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if ((rule == RULE_REDIRECT) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_rs_used, id_rt_used, ex_mem_read, ex_redirect;
  logic        mem_access, icache_hit, dcache_hit;

  logic        pc_en, if_id_en, id_ex_hit, ex_mem_en, mem_wb_en;
  logic        if_id_flush, id_ex_flush;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        pc_en4, if_id_en4, id_ex_hit4, ex_mem_en4, mem_wb_en4;
  logic        if_id_flush4, id_ex_flush4;
  logic [1:0]  state4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  pipe_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .icache_hit(icache_hit), .dcache_hit(dcache_hit),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_hit(id_ex_hit),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_redirect(ex_redirect),
    .mem_access(mem_access), .icache_hit(icache_hit), .dcache_hit(dcache_hit),
    .pc_en(pc_en4), .if_id_en(if_id_en4), .id_ex_hit(id_ex_hit4),
    .ex_mem_en(ex_mem_en4), .mem_wb_en(mem_wb_en4),
    .if_id_flush(if_id_flush4), .id_ex_flush(id_ex_flush4),
    .state(state4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  // Clock: falling edges (active) at 5,15,..., rising edges at 10,20,...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_used;
    logic       rt_used;
    logic       mem_read;
    logic [4:0] ert;
    logic       redirect;
    logic       maccess;
    logic       ihit;
    logic       dhit;
    logic [4:0] en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] fl;   // {if_id_flush, id_ex_flush}
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_rs_used = 1'b0; id_rt_used = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0; ex_redirect = 1'b0;
    mem_access = 1'b0; icache_hit = 1'b1; dcache_hit = 1'b1;
  endtask

  // Drive point: 1 time unit after the rising edge, well away from the falling edge.
  task automatic drive_pt();
    @(posedge clk);
    #1;
  endtask

  // Let the active (falling) edge pass and settle.
  task automatic after_fall();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [4:0] enables();
    return {pc_en, if_id_en, id_ex_hit, ex_mem_en, mem_wb_en};
  endfunction

  function automatic logic [1:0] flushes();
    return {if_id_flush, id_ex_flush};
  endfunction

  task automatic do_reset();
    drive_pt();
    idle();
    rst_n = 1'b0;
    after_fall();
    drive_pt();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 2'b00};
    vecs[1]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00111, 2'b01};
    vecs[2]  = '{5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 5'b00111, 2'b01};
    vecs[3]  = '{5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 2'b00};
    vecs[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 2'b00};
    vecs[5]  = '{5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1, 1'b1, 5'b11111, 2'b00};
    vecs[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11111, 2'b11};
    vecs[7]  = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 5'b11111, 2'b11};
    vecs[8]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00111, 2'b01};
    vecs[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'b00000, 2'b00};
    vecs[10] = '{5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 2'b00};
    vecs[11] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'b11111, 2'b00};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11111, 2'b11};
    vecs[13] = '{5'd9, 5'd9, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b1, 5'b00111, 2'b01};
    vecs[14] = '{5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11111, 2'b00};

    idle();
    rst_n = 1'b0;
    #2;
    // Reset state, sampled while rst_n is low.
    check("reset_enables", 32'(enables()), 32'h0);
    check("reset_flushes", 32'(flushes()), 32'h0);
    after_fall();
    check("reset_state", 32'(state), 32'h0);
    check("reset_stall_cnt", 32'(stall_cnt), 32'h0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'h0);
    drive_pt();
    rst_n = 1'b1;

    // Table-driven combinational rule checks.
    for (int i = 0; i < 15; i++) begin
      drive_pt();
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_rs_used = vecs[i].rs_used; id_rt_used = vecs[i].rt_used;
      ex_mem_read = vecs[i].mem_read; ex_rt = vecs[i].ert;
      ex_redirect = vecs[i].redirect; mem_access = vecs[i].maccess;
      icache_hit = vecs[i].ihit; dcache_hit = vecs[i].dhit;
      #1;
      check($sformatf("vec%0d_enables", i), 32'(enables()), 32'(vecs[i].en));
      check($sformatf("vec%0d_flushes", i), 32'(flushes()), 32'(vecs[i].fl));
    end

    // Load-use: one-cycle stall, then normal.
    do_reset();
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1;
    #1;
    check("lu_pc_en", 32'(pc_en), 32'h0);
    check("lu_id_ex_flush", 32'(id_ex_flush), 32'h1);
    after_fall();
    check("lu_stall_cnt", 32'(stall_cnt), 32'h1);
    drive_pt();
    idle();
    #1;
    check("lu_next_enables", 32'(enables()), 32'h1f);
    after_fall();
    check("lu_stall_cnt_hold", 32'(stall_cnt), 32'h1);
    check("lu_state", 32'(state), 32'h0);

    // $0 destination never stalls.
    drive_pt();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rs_used = 1'b1;
    #1;
    check("r0_pc_en", 32'(pc_en), 32'h1);
    after_fall();
    check("r0_stall_cnt", 32'(stall_cnt), 32'h1);

    // D-miss 4 cycles with a redirect waiting in EX.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      mem_access = 1'b1; dcache_hit = 1'b0; ex_redirect = 1'b1;
      #1;
      check($sformatf("dm_enables_c%0d", c), 32'(enables()), 32'h0);
      check($sformatf("dm_flushes_c%0d", c), 32'(flushes()), 32'h0);
      after_fall();
      check($sformatf("dm_state_c%0d", c), 32'(state), 32'h2);
      drive_pt();
    end
    check("dm_stall_cnt", 32'(stall_cnt), 32'h4);
    check("dm_flush_cnt_pre", 32'(flush_cnt), 32'h0);
    dcache_hit = 1'b1;
    #1;
    check("dm_redir_enables", 32'(enables()), 32'h1f);
    check("dm_redir_flushes", 32'(flushes()), 32'h3);
    after_fall();
    check("dm_flush_cnt", 32'(flush_cnt), 32'h1);
    check("dm_stall_cnt_hold", 32'(stall_cnt), 32'h4);
    check("dm_state_run", 32'(state), 32'h0);

    // I-miss, redirect on its 3rd cycle aborts it.
    do_reset();
    icache_hit = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      check($sformatf("im_pc_en_c%0d", c), 32'(pc_en), 32'h0);
      after_fall();
      check($sformatf("im_state_c%0d", c), 32'(state), 32'h1);
      drive_pt();
    end
    ex_redirect = 1'b1;
    #1;
    check("im_redir_pc_en", 32'(pc_en), 32'h1);
    check("im_redir_if_id_flush", 32'(if_id_flush), 32'h1);
    after_fall();
    check("im_state_run", 32'(state), 32'h0);
    check("im_stall_cnt", 32'(stall_cnt), 32'h2);
    check("im_flush_cnt", 32'(flush_cnt), 32'h1);

    // DMISS exiting with the I-cache also missing goes to IMISS.
    do_reset();
    mem_access = 1'b1; dcache_hit = 1'b0;
    after_fall();
    check("first_edge_state", 32'(state), 32'h2);
    check("first_edge_stall", 32'(stall_cnt), 32'h1);
    drive_pt();
    dcache_hit = 1'b1; icache_hit = 1'b0;
    after_fall();
    check("dm_to_im_state", 32'(state), 32'h1);

    // Saturation: 20 stall cycles.
    do_reset();
    mem_access = 1'b1; dcache_hit = 1'b0;
    for (int c = 0; c < 20; c++) after_fall();
    check("sat_stall_cnt4", 32'(stall_cnt4), 32'hf);
    check("sat_stall_cnt16", 32'(stall_cnt), 32'd20);
    check("sat_state4", 32'(state4), 32'h2);

    // Asynchronous reset mid D-miss, away from any clock edge.
    drive_pt();
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_state", 32'(state), 32'h0);
    check("areset_stall_cnt", 32'(stall_cnt), 32'h0);
    check("areset_stall_cnt4", 32'(stall_cnt4), 32'h0);
    check("areset_flush_cnt", 32'(flush_cnt), 32'h0);
    check("areset_enables", 32'(enables()), 32'h0);
    idle();
    drive_pt();
    rst_n = 1'b1;
    after_fall();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1);
  end

endmodule
